// File: rtl/somador_serial_pkg.sv
// Shared definitions for the bit-serial add/subtract controller:
// FSM state encodings, operation encodings and a small operand helper.
package somador_serial_pkg;

  // Controller states; 2'b11 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADD  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Operation select encodings.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Subtraction is A + ~B + 1, so a subtract both inverts B and seeds the carry.
  function automatic logic op_is_sub(input logic op);
    return (op == OP_SUB);
  endfunction

endpackage

// File: rtl/meio_somador.sv
// Half-adder cell: sum and carry of two single bits.
module meio_somador (
  output logic S,
  output logic C,
  input  logic A,
  input  logic B
);

  assign S = A ^ B;
  assign C = A & B;

endmodule

// File: rtl/somador_completo.sv
// Structural 1-bit full adder: two half-adder cells chained, with the two
// partial carries merged by an OR gate (they can never both be high).
module somador_completo (
  output logic S,
  output logic Cout,
  input  logic A,
  input  logic B,
  input  logic Cin
);

  logic p_s;
  logic c1_s;
  logic c2_s;

  meio_somador u_ha0 (
    .S (p_s),
    .C (c1_s),
    .A (A),
    .B (B)
  );

  meio_somador u_ha1 (
    .S (S),
    .C (c2_s),
    .A (p_s),
    .B (Cin)
  );

  assign Cout = c1_s | c2_s;

endmodule

// File: rtl/somador_serial.sv
// Bit-serial add/subtract controller. One full-adder stage is reused over
// WIDTH cycles, LSB first; the result and final carry are published with a
// one-cycle done pulse. For subtract, cout=1 means no borrow (A >= B).
module somador_serial
  import somador_serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int              CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;

  logic             fa_sum_s;
  logic             fa_carry_s;

  // The single arithmetic stage, fed from the operand LSBs and the carry.
  somador_completo u_fa (
    .S    (fa_sum_s),
    .Cout (fa_carry_s),
    .A    (sa_q[0]),
    .B    (sb_q[0]),
    .Cin  (carry_q)
  );

  // Next result value: shift right and insert the new sum bit at the MSB.
  always_comb begin
    res_d            = res_q >> 1'b1;
    res_d[WIDTH-1]   = fa_sum_s;
  end

  // Controller FSM with operand/result shift registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            sa_q    <= a;
            sb_q    <= op_is_sub(op) ? ~b : b;
            carry_q <= op_is_sub(op);
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_ADD;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_ADD: begin
          res_q   <= res_d;
          sa_q    <= sa_q >> 1'b1;
          sb_q    <= sb_q >> 1'b1;
          carry_q <= fa_carry_s;
          cnt_q   <= cnt_q + 1'b1;
          busy_q  <= 1'b1;
          if (cnt_q == CNT_LAST) begin
            sum_q   <= res_d;
            cout_q  <= fa_carry_s;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            done_q  <= 1'b0;
            state_q <= ST_ADD;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_somador_serial.sv
// Scoreboard bench for somador_serial: stimulus pushes expected results,
// per-DUT monitors pop and compare on every done pulse (WIDTH=8 and WIDTH=1).
`timescale 1ns/1ps
module tb_somador_serial;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, op8;
  logic [7:0] a8, b8;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;
  logic       start1, op1;
  logic [0:0] a1, b1;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [7:0] s;
    logic       c;
    int         at;
  } exp_t;

  exp_t q8[$];
  exp_t q1[$];
  exp_t e8;
  exp_t e1;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  somador_serial #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  somador_serial #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .op(op1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the WIDTH=8 instance.
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      chk("done8_implies_busy", {31'd0, busy8}, 32'd1);
      if (q8.size() == 0) begin
        total++;
        bad++;
        $display("FAIL done8_unexpected: got done=1 want no pulse (cycle %0d)", cyc);
      end else begin
        e8 = q8.pop_front();
        chk("sum8", {24'd0, sum8}, {24'd0, e8.s});
        chk("cout8", {31'd0, cout8}, {31'd0, e8.c});
        chk("done8_cycle", cyc, e8.at);
      end
    end
  end

  // Monitor for the WIDTH=1 instance.
  always @(negedge clk) begin
    if (done1 === 1'b1) begin
      chk("done1_implies_busy", {31'd0, busy1}, 32'd1);
      if (q1.size() == 0) begin
        total++;
        bad++;
        $display("FAIL done1_unexpected: got done=1 want no pulse (cycle %0d)", cyc);
      end else begin
        e1 = q1.pop_front();
        chk("sum1", {31'd0, sum1}, {31'd0, e1.s[0]});
        chk("cout1", {31'd0, cout1}, {31'd0, e1.c});
        chk("done1_cycle", cyc, e1.at);
      end
    end
  end

  task automatic push8(input logic [7:0] s, input logic c, input int at);
    exp_t e;
    e.s = s; e.c = c; e.at = at;
    q8.push_back(e);
  endtask

  task automatic push1(input logic s, input logic c, input int at);
    exp_t e;
    e.s = {7'd0, s}; e.c = c; e.at = at;
    q1.push_back(e);
  endtask

  // One WIDTH=8 operation with a single-cycle start; returns with the DUT idle.
  task automatic go8(input logic o, input logic [7:0] x, input logic [7:0] y,
                     input logic [7:0] s, input logic c);
    @(negedge clk);
    op8 = o; a8 = x; b8 = y; start8 = 1'b1;
    push8(s, c, cyc + 1 + 8);
    @(negedge clk);
    start8 = 1'b0; a8 = ~x; b8 = ~y; op8 = ~o;
    repeat (9) @(negedge clk);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    start8 = 1'b0; op8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    start1 = 1'b0; op1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy8", {31'd0, busy8}, 32'd0);
    chk("rst_done8", {31'd0, done8}, 32'd0);
    chk("rst_sum8", {24'd0, sum8}, 32'd0);
    chk("rst_cout8", {31'd0, cout8}, 32'd0);
    chk("rst_busy1", {31'd0, busy1}, 32'd0);
    chk("rst_done1", {31'd0, done1}, 32'd0);
    chk("rst_sum1", {31'd0, sum1}, 32'd0);
    chk("rst_cout1", {31'd0, cout1}, 32'd0);
    rst_n = 1'b1;

    // 0x3C + 0x5A with busy duration measured.
    @(negedge clk);
    op8 = 1'b0; a8 = 8'h3C; b8 = 8'h5A; start8 = 1'b1;
    push8(8'h96, 1'b0, cyc + 1 + 8);
    @(negedge clk);
    start8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy8 === 1'b1) n++;
      @(negedge clk);
    end
    chk("busy8_cycles", n, 32'd9);

    go8(1'b0, 8'hFF, 8'h01, 8'h00, 1'b1);
    go8(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    go8(1'b1, 8'h10, 8'h01, 8'h0F, 1'b1);
    go8(1'b1, 8'h01, 8'h02, 8'hFF, 1'b0);

    // Starts during ADD cycle 3 and during DONE must be ignored.
    @(negedge clk);
    op8 = 1'b0; a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
    push8(8'h02, 1'b0, cyc + 1 + 8);
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    op8 = 1'b1; a8 = 8'h7F; b8 = 8'h7F; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (5) @(negedge clk);
    op8 = 1'b1; a8 = 8'h7F; b8 = 8'h7F; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);

    // Reset mid-operation: no done, outputs cleared.
    @(negedge clk);
    op8 = 1'b0; a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy8", {31'd0, busy8}, 32'd0);
    chk("abort_done8", {31'd0, done8}, 32'd0);
    chk("abort_sum8", {24'd0, sum8}, 32'd0);
    chk("abort_cout8", {31'd0, cout8}, 32'd0);
    repeat (12) @(negedge clk);
    go8(1'b0, 8'h01, 8'h02, 8'h03, 1'b0);

    // Start held high: re-accepted every 10 cycles.
    @(negedge clk);
    op8 = 1'b0; a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
    push8(8'h46, 1'b0, cyc + 1 + 8);
    push8(8'h46, 1'b0, cyc + 1 + 18);
    push8(8'h46, 1'b0, cyc + 1 + 28);
    repeat (21) @(negedge clk);
    start8 = 1'b0;
    repeat (12) @(negedge clk);

    // WIDTH=1: 0 - 1 gives 1 with a borrow.
    @(negedge clk);
    op1 = 1'b1; a1 = 1'b0; b1 = 1'b1; start1 = 1'b1;
    push1(1'b1, 1'b0, cyc + 1 + 1);
    @(negedge clk);
    start1 = 1'b0; op1 = 1'b0;
    repeat (3) @(negedge clk);

    // WIDTH=1 with start held: 1 + 1 every 3 cycles.
    @(negedge clk);
    op1 = 1'b0; a1 = 1'b1; b1 = 1'b1; start1 = 1'b1;
    push1(1'b0, 1'b1, cyc + 1 + 1);
    push1(1'b0, 1'b1, cyc + 1 + 4);
    push1(1'b0, 1'b1, cyc + 1 + 7);
    repeat (7) @(negedge clk);
    start1 = 1'b0;

    for (int i = 0; i < 50 && (q8.size() + q1.size()) != 0; i++) @(negedge clk);
    chk("pending_expectations", q8.size() + q1.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
